// File: rtl/aes_byte_loader.sv
// Assembles NBYTES switch-entered bytes (first byte in the MSBs) into one block and offers it with valid/ready.
// Optional macro LOADER_EDGE_DETECT_EN: treat byte_strobe as a raw push-button level (synchronised + rising-edge detected).
module aes_byte_loader #(
    parameter int NBYTES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            byte_in,
    input  logic                  byte_strobe,
    input  logic                  clear,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   block_out,
    output logic                  out_valid,
    output logic [5:0]            byte_count,
    output logic                  overrun,
    output logic [0:0]            fsm_state
);

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;
    localparam logic [5:0] LAST = 6'(NBYTES - 1);

    // Handshake: the block transfers on an edge where out_valid and out_ready are both high.
    logic capture;
    logic [0:0] state;

`ifdef LOADER_EDGE_DETECT_EN
    // Two synchroniser flops plus one history flop; capture fires for one cycle per rising edge.
    logic [2:0] strobe_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe_sync <= 3'b000;
        end else begin
            strobe_sync <= {strobe_sync[1:0], byte_strobe};
        end
    end

    assign capture = strobe_sync[1] & ~strobe_sync[2];
`else
    assign capture = byte_strobe;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FILL;
            block_out  <= '0;
            out_valid  <= 1'b0;
            byte_count <= 6'd0;
            overrun    <= 1'b0;
        end else if (clear) begin
            state      <= FILL;
            block_out  <= '0;
            out_valid  <= 1'b0;
            byte_count <= 6'd0;
            overrun    <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (capture) begin
                        for (int i = 0; i < NBYTES; i++) begin
                            if (byte_count == 6'(i)) begin
                                block_out[8*(NBYTES-i)-1 -: 8] <= byte_in;
                            end
                        end
                        byte_count <= byte_count + 6'd1;
                        if (byte_count == LAST) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // A strobe here is dropped, even on the edge that hands the block off.
                    if (capture) begin
                        overrun <= 1'b1;
                    end
                    if (out_valid && out_ready) begin
                        state      <= FILL;
                        byte_count <= 6'd0;
                        out_valid  <= 1'b0;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_aes_byte_loader.sv
// Bench for aes_byte_loader: a 16-byte and a 32-byte instance, scenario tasks and a block scoreboard.
module tb_aes_byte_loader;

    logic         clk;
    logic         reset;
    logic [7:0]   byte_in;
    logic         clear;
    logic         strobe16, ready16, strobe32, ready32;
    logic [127:0] block16;
    logic [255:0] block32;
    logic         valid16, valid32, overrun16, overrun32;
    logic [5:0]   count16, count32;
    logic [0:0]   state16, state32;

    logic [255:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    aes_byte_loader #(.NBYTES(16)) dut16 (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_strobe(strobe16),
        .clear(clear), .out_ready(ready16), .block_out(block16), .out_valid(valid16),
        .byte_count(count16), .overrun(overrun16), .fsm_state(state16)
    );

    aes_byte_loader #(.NBYTES(32)) dut32 (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_strobe(strobe32),
        .clear(clear), .out_ready(ready32), .block_out(block32), .out_valid(valid32),
        .byte_count(count32), .overrun(overrun32), .fsm_state(state32)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Driver: 16 single-cycle-each back-to-back strobes into dut16; expected block queued.
    task automatic fill16(input bit ramp);
        logic [255:0] exp;
        logic [7:0]   b;
        exp = '0;
        for (int i = 0; i < 16; i++) begin
            b = ramp ? 8'(i * 17) : 8'($urandom_range(0, 255));
            @(negedge clk);
            byte_in  = b;
            strobe16 = 1'b1;
            exp = {exp[247:0], b};
        end
        @(negedge clk);
        strobe16 = 1'b0;
        exp_q.push_back(exp);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (count16 !== 6'd0) begin n_fail++; $display("FAIL reset_count16: got %0d want 0", count16); end
        n_cmp++; if (valid16 !== 1'b0) begin n_fail++; $display("FAIL reset_valid16: got %b want 0", valid16); end
        n_cmp++; if (block16 !== '0) begin n_fail++; $display("FAIL reset_block16: got %h want 0", block16); end
        n_cmp++; if (overrun16 !== 1'b0) begin n_fail++; $display("FAIL reset_overrun16: got %b want 0", overrun16); end
        n_cmp++; if (state16 !== 1'b0) begin n_fail++; $display("FAIL reset_state16: got %b want 0", state16); end
        n_cmp++; if (block32 !== '0 || count32 !== 6'd0) begin n_fail++; $display("FAIL reset_dut32: block %h count %0d want 0", block32, count32); end
        reset = 1'b0;
    endtask

    task automatic test_fill16();
        logic [255:0] got;
        fill16(1'b1);
        n_cmp++; if (valid16 !== 1'b1) begin n_fail++; $display("FAIL fill16_valid: got %b want 1", valid16); end
        n_cmp++; if (count16 !== 6'd16) begin n_fail++; $display("FAIL fill16_count: got %0d want 16", count16); end
        n_cmp++; if (block16 !== 128'h00112233445566778899aabbccddeeff) begin n_fail++; $display("FAIL fill16_const: got %h want 00112233445566778899aabbccddeeff", block16); end
        if (valid16 === 1'b1 && exp_q.size() > 0) begin
            got = exp_q.pop_front();
            n_cmp++; if ({128'b0, block16} !== got) begin n_fail++; $display("FAIL fill16_sb: got %h want %h", block16, got[127:0]); end
        end
        // HOLD freezes, out_ready low
        repeat (3) @(negedge clk);
        n_cmp++; if (count16 !== 6'd16 || valid16 !== 1'b1) begin n_fail++; $display("FAIL hold_frozen: count %0d valid %b want 16 1", count16, valid16); end
        ready16 = 1'b1;
        @(negedge clk);
        ready16 = 1'b0;
        n_cmp++; if (valid16 !== 1'b0 || count16 !== 6'd0) begin n_fail++; $display("FAIL handshake16: valid %b count %0d want 0 0", valid16, count16); end
        n_cmp++; if (block16 !== 128'h00112233445566778899aabbccddeeff) begin n_fail++; $display("FAIL handshake_keep: got %h want 00112233445566778899aabbccddeeff", block16); end
        n_cmp++; if (state16 !== 1'b0) begin n_fail++; $display("FAIL handshake_state: got %b want 0", state16); end
    endtask

    task automatic test_back_to_back();
        logic [255:0] got;
        // out_ready high during FILL must not disturb the fill
        ready16 = 1'b1;
        fill16(1'b0);
        ready16 = 1'b0;
        n_cmp++; if (count16 !== 6'd16 || valid16 !== 1'b1) begin n_fail++; $display("FAIL b2b_fill: count %0d valid %b want 16 1", count16, valid16); end
        if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            n_cmp++; if ({128'b0, block16} !== got) begin n_fail++; $display("FAIL b2b_sb: got %h want %h", block16, got[127:0]); end
        end
        do_clear();
    endtask

    task automatic test_overrun();
        logic [255:0] got;
        fill16(1'b0);
        got = exp_q.size() > 0 ? exp_q.pop_front() : '0;
        @(negedge clk);
        byte_in = 8'hAA; strobe16 = 1'b1;
        @(negedge clk);
        strobe16 = 1'b0;
        n_cmp++; if (overrun16 !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b want 1", overrun16); end
        n_cmp++; if ({128'b0, block16} !== got) begin n_fail++; $display("FAIL overrun_block: got %h want %h", block16, got[127:0]); end
        n_cmp++; if (count16 !== 6'd16) begin n_fail++; $display("FAIL overrun_count: got %0d want 16", count16); end
        do_clear();
        n_cmp++; if (overrun16 !== 1'b0 || block16 !== '0) begin n_fail++; $display("FAIL overrun_clear: overrun %b block %h want 0 0", overrun16, block16); end
        // strobe on the handshake edge: block leaves, byte dropped, overrun set
        fill16(1'b1);
        void'(exp_q.pop_front());
        @(negedge clk);
        byte_in = 8'h5A; strobe16 = 1'b1; ready16 = 1'b1;
        @(negedge clk);
        strobe16 = 1'b0; ready16 = 1'b0;
        n_cmp++; if (overrun16 !== 1'b1 || count16 !== 6'd0 || valid16 !== 1'b0) begin n_fail++; $display("FAIL hs_strobe: overrun %b count %0d valid %b want 1 0 0", overrun16, count16, valid16); end
        n_cmp++; if (block16[127:120] !== 8'h00) begin n_fail++; $display("FAIL hs_strobe_byte: got %h want 00", block16[127:120]); end
        do_clear();
    endtask

    task automatic test_clear_priority();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            byte_in = 8'(8'h40 + i); strobe16 = 1'b1;
        end
        @(negedge clk);
        strobe16 = 1'b0;
        n_cmp++; if (count16 !== 6'd7) begin n_fail++; $display("FAIL partial_count: got %0d want 7", count16); end
        byte_in = 8'h77; strobe16 = 1'b1; clear = 1'b1;
        @(negedge clk);
        strobe16 = 1'b0; clear = 1'b0;
        n_cmp++; if (count16 !== 6'd0 || block16 !== '0) begin n_fail++; $display("FAIL clear_vs_strobe: count %0d block %h want 0 0", count16, block16); end
        byte_in = 8'h12; strobe16 = 1'b1;
        @(negedge clk);
        strobe16 = 1'b0;
        n_cmp++; if (count16 !== 6'd1 || block16[127:120] !== 8'h12) begin n_fail++; $display("FAIL restart_pos: count %0d top %h want 1 12", count16, block16[127:120]); end
        do_clear();
        // clear beats a handshake on the same edge
        fill16(1'b1);
        void'(exp_q.pop_front());
        ready16 = 1'b1; clear = 1'b1;
        @(negedge clk);
        ready16 = 1'b0; clear = 1'b0;
        n_cmp++; if (valid16 !== 1'b0 || count16 !== 6'd0 || block16 !== '0) begin n_fail++; $display("FAIL clear_vs_hs: valid %b count %0d block %h want 0 0 0", valid16, count16, block16); end
    endtask

    task automatic test_fill32();
        logic [255:0] got;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            byte_in = 8'(i); strobe32 = 1'b1;
        end
        @(negedge clk);
        strobe32 = 1'b0;
        exp_q.push_back(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        n_cmp++; if (valid32 !== 1'b1 || count32 !== 6'd32) begin n_fail++; $display("FAIL fill32: valid %b count %0d want 1 32", valid32, count32); end
        if (valid32 === 1'b1 && exp_q.size() > 0) begin
            got = exp_q.pop_front();
            n_cmp++; if (block32 !== got) begin n_fail++; $display("FAIL fill32_sb: got %h want %h", block32, got); end
        end
        ready32 = 1'b1;
        @(negedge clk);
        ready32 = 1'b0;
        n_cmp++; if (valid32 !== 1'b0 || count32 !== 6'd0) begin n_fail++; $display("FAIL hs32: valid %b count %0d want 0 0", valid32, count32); end
        do_clear();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            byte_in = 8'(8'hC0 + i); strobe16 = 1'b1;
        end
        @(negedge clk);
        strobe16 = 1'b0;
        n_cmp++; if (count16 !== 6'd9) begin n_fail++; $display("FAIL pre_reset_count: got %0d want 9", count16); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (count16 !== 6'd0 || block16 !== '0 || valid16 !== 1'b0 || overrun16 !== 1'b0) begin n_fail++; $display("FAIL async_reset: count %0d block %h valid %b overrun %b want all 0", count16, block16, valid16, overrun16); end
        #1 reset = 1'b0;
        byte_in = 8'h5A; strobe16 = 1'b1;
        @(negedge clk);
        strobe16 = 1'b0;
        n_cmp++; if (count16 !== 6'd1 || block16[127:120] !== 8'h5A) begin n_fail++; $display("FAIL first_capture: count %0d top %h want 1 5a", count16, block16[127:120]); end
        do_clear();
    endtask

`ifdef LOADER_EDGE_DETECT_EN
    task automatic test_edge_detect();
        @(negedge clk);
        byte_in = 8'h3C; strobe16 = 1'b1;
        @(negedge clk);
        n_cmp++; if (count16 !== 6'd0) begin n_fail++; $display("FAIL edge_e1: got %0d want 0", count16); end
        @(negedge clk);
        n_cmp++; if (count16 !== 6'd0) begin n_fail++; $display("FAIL edge_e2: got %0d want 0", count16); end
        @(negedge clk);
        n_cmp++; if (count16 !== 6'd1) begin n_fail++; $display("FAIL edge_e3: got %0d want 1", count16); end
        repeat (7) @(negedge clk);
        strobe16 = 1'b0;
        n_cmp++; if (count16 !== 6'd1) begin n_fail++; $display("FAIL edge_held: got %0d want 1", count16); end
        n_cmp++; if (block16[127:120] !== 8'h3C) begin n_fail++; $display("FAIL edge_byte: got %h want 3c", block16[127:120]); end
        do_clear();
    endtask
`endif

    initial begin
        byte_in = 8'h00; clear = 1'b0;
        strobe16 = 1'b0; ready16 = 1'b0; strobe32 = 1'b0; ready32 = 1'b0;
        test_reset();
`ifdef LOADER_EDGE_DETECT_EN
        test_edge_detect();
`else
        test_fill16();
        test_back_to_back();
        test_overrun();
        test_clear_priority();
        test_fill32();
        test_async_reset();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
